// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with write-first bypass and a busy scoreboard
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  localparam int AW = $clog2(NREGS),
  parameter logic [31:0] RA_INIT = 32'h0000_0068,
  parameter logic [31:0] SP_INIT = 32'd1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NRD-1:0]     rd_en,
  input  logic [NRD*AW-1:0]  ra,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]     rd_busy,
  output logic               stall,
  input  logic               we,
  input  logic [AW-1:0]      wa,
  input  logic [XLEN-1:0]    wd,
  input  logic               alloc_valid,
  input  logic [AW-1:0]      alloc_rd,
  input  logic               flush,
  output logic [AW:0]        busy_count
);
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy, busy_nxt;
  logic alloc_ok, inc, dec;
  assign alloc_ok = alloc_valid && alloc_rd != '0;
  assign inc = !flush && alloc_ok && !busy[alloc_rd];
  assign dec = !flush && we && busy[wa] && !(alloc_ok && alloc_rd == wa);
  always_comb begin
    busy_nxt = busy;
    if (flush) busy_nxt = '0;
    else begin
      if (we) busy_nxt[wa] = 1'b0;
      if (alloc_ok) busy_nxt[alloc_rd] = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= i == 1 ? XLEN'(RA_INIT) : i == 2 ? XLEN'(SP_INIT) : '0;
      busy <= '0;
      busy_count <= '0;
    end else begin
      if (we && wa != '0) regs[wa] <= wd;
      busy <= busy_nxt;
      busy_count <= flush ? '0 : busy_count + (AW+1)'(inc) - (AW+1)'(dec);
    end
  end
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] a;
    logic hit;
    assign a = ra[g*AW +: AW];
    assign hit = we && wa == a;
    assign rdata[g*XLEN +: XLEN] = a == '0 ? '0 : hit ? wd : regs[a];
    assign rd_busy[g] = a != '0 && busy[a] && !hit;
  end
  assign stall = |(rd_en & rd_busy);
endmodule
